// File: rtl/host_cmd_router.sv
`timescale 1ns/1ps
// Host command router: splits the host word stream into instruction-FIFO and pulse-FIFO
// writes, enforcing packet framing (tlast, payload length, stall timeout) and counting errors.
module host_cmd_router #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_tready,
    input  logic        instr_fifo_full,
    output logic        instr_fifo_wr_en,
    output logic [31:0] instr_fifo_wr_data,
    input  logic        pulse_fifo_full,
    output logic        pulse_fifo_wr_en,
    output logic [31:0] pulse_fifo_wr_data,
    output logic [15:0] err_count,
    output logic [7:0]  state_out,
    output logic        busy
);
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_PAYLOAD = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    localparam logic [7:0] OP_NOP  = 8'h00;
    localparam logic [7:0] OP_LOAD = 8'h01;

    logic [1:0]        state, state_nxt;
    logic [15:0]       pay_cnt, pay_cnt_nxt;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
    logic              accept;
    logic              err_inc;
    logic              instr_wr;
    logic              pulse_wr;
    logic [7:0]        opcode;
    logic [15:0]       hdr_count;

    logic              instr_vld_p1;
    logic [31:0]       instr_data_p1;
    logic              pulse_vld_p1;
    logic [31:0]       pulse_data_p1;
    logic [15:0]       err_cnt_p1;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Ready depends only on state and the almost-full flags, never on tvalid.
    always_comb begin
        s_axis_tready = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE:    s_axis_tready = !instr_fifo_full;
                ST_PAYLOAD: s_axis_tready = !pulse_fifo_full;
                ST_DRAIN:   s_axis_tready = 1'b1;
                default:    s_axis_tready = 1'b0;
            endcase
        end
    end

    assign accept    = s_axis_tvalid & s_axis_tready;
    assign opcode    = s_axis_tdata[31:24];
    assign hdr_count = s_axis_tdata[15:0];

    always_comb begin
        state_nxt    = state;
        pay_cnt_nxt  = pay_cnt;
        idle_cnt_nxt = idle_cnt;
        err_inc      = 1'b0;
        instr_wr     = 1'b0;
        pulse_wr     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (opcode == OP_NOP) begin
                        if (!s_axis_tlast) begin
                            err_inc   = 1'b1;
                            state_nxt = ST_DRAIN;
                        end
                    end else if (opcode == OP_LOAD) begin
                        if (hdr_count == 16'd0) begin
                            if (!s_axis_tlast) begin
                                err_inc   = 1'b1;
                                state_nxt = ST_DRAIN;
                            end
                        end else if (s_axis_tlast) begin
                            err_inc = 1'b1;
                        end else begin
                            pay_cnt_nxt  = hdr_count;
                            idle_cnt_nxt = '0;
                            state_nxt    = ST_PAYLOAD;
                        end
                    end else begin
                        instr_wr = 1'b1;
                        if (!s_axis_tlast) begin
                            err_inc   = 1'b1;
                            state_nxt = ST_DRAIN;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    pulse_wr     = 1'b1;
                    idle_cnt_nxt = '0;
                    pay_cnt_nxt  = pay_cnt - 16'd1;
                    if (pay_cnt == 16'd1) begin
                        if (s_axis_tlast) begin
                            state_nxt = ST_IDLE;
                        end else begin
                            err_inc   = 1'b1;
                            state_nxt = ST_DRAIN;
                        end
                    end else if (s_axis_tlast) begin
                        err_inc     = 1'b1;
                        pay_cnt_nxt = 16'd0;
                        state_nxt   = ST_IDLE;
                    end
                end else if (!s_axis_tvalid) begin
                    // Back-pressured cycles (tvalid high, FIFO full) neither count nor clear.
                    if (idle_cnt == IDLE_LAST) begin
                        err_inc      = 1'b1;
                        pay_cnt_nxt  = 16'd0;
                        idle_cnt_nxt = '0;
                        state_nxt    = ST_IDLE;
                    end else begin
                        idle_cnt_nxt = idle_cnt + IDLE_W'(1);
                    end
                end
            end
            ST_DRAIN: begin
                if (accept && s_axis_tlast) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Stage p1: registered FIFO writes and error counter, one cycle after the accepting edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            pay_cnt       <= '0;
            idle_cnt      <= '0;
            err_cnt_p1    <= '0;
            instr_vld_p1  <= 1'b0;
            pulse_vld_p1  <= 1'b0;
            instr_data_p1 <= '0;
            pulse_data_p1 <= '0;
        end else begin
            state        <= state_nxt;
            pay_cnt      <= pay_cnt_nxt;
            idle_cnt     <= idle_cnt_nxt;
            instr_vld_p1 <= instr_wr;
            pulse_vld_p1 <= pulse_wr;
            if (instr_wr) begin
                instr_data_p1 <= s_axis_tdata;
            end
            if (pulse_wr) begin
                pulse_data_p1 <= s_axis_tdata;
            end
            if (err_inc) begin
                err_cnt_p1 <= sat_inc16(err_cnt_p1);
            end
        end
    end

    assign instr_fifo_wr_en   = instr_vld_p1;
    assign instr_fifo_wr_data = instr_data_p1;
    assign pulse_fifo_wr_en   = pulse_vld_p1;
    assign pulse_fifo_wr_data = pulse_data_p1;
    assign err_count          = err_cnt_p1;
    assign state_out          = {6'd0, state};
    assign busy               = (state != ST_IDLE) | instr_vld_p1 | pulse_vld_p1;

endmodule

// File: tb/tb_host_cmd_router.sv
`timescale 1ns/1ps
// Self-checking bench for host_cmd_router: directed framing scenarios plus a randomized
// packet stream compared against a beat-level reference model of the routing rules.
module tb_host_cmd_router;
    logic        clk;
    logic        rst;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_tready;
    logic        instr_fifo_full;
    logic        instr_fifo_wr_en;
    logic [31:0] instr_fifo_wr_data;
    logic        pulse_fifo_full;
    logic        pulse_fifo_wr_en;
    logic [31:0] pulse_fifo_wr_data;
    logic [15:0] err_count;
    logic [7:0]  state_out;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    bit gap_en = 0;
    bit bp_en  = 0;

    logic [31:0] mon_instr_q[$];
    logic [31:0] mon_pulse_q[$];
    int          mon_instr_c[$];
    int          mon_pulse_c[$];
    logic [31:0] beat_d[$];
    logic        beat_l[$];
    logic [31:0] exp_instr[$];
    logic [31:0] exp_pulse[$];

    host_cmd_router #(.TIMEOUT_CYCLES(16)) dut (
        .clk                (clk),
        .rst                (rst),
        .s_axis_tdata       (s_axis_tdata),
        .s_axis_tvalid      (s_axis_tvalid),
        .s_axis_tlast       (s_axis_tlast),
        .s_axis_tready      (s_axis_tready),
        .instr_fifo_full    (instr_fifo_full),
        .instr_fifo_wr_en   (instr_fifo_wr_en),
        .instr_fifo_wr_data (instr_fifo_wr_data),
        .pulse_fifo_full    (pulse_fifo_full),
        .pulse_fifo_wr_en   (pulse_fifo_wr_en),
        .pulse_fifo_wr_data (pulse_fifo_wr_data),
        .err_count          (err_count),
        .state_out          (state_out),
        .busy               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (instr_fifo_wr_en) begin
            mon_instr_q.push_back(instr_fifo_wr_data);
            mon_instr_c.push_back(cyc);
        end
        if (pulse_fifo_wr_en) begin
            mon_pulse_q.push_back(pulse_fifo_wr_data);
            mon_pulse_c.push_back(cyc);
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic clear_mon();
        mon_instr_q.delete();
        mon_pulse_q.delete();
        mon_instr_c.delete();
        mon_pulse_c.delete();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        s_axis_tdata = '0;
        instr_fifo_full = 1'b0;
        pulse_fifo_full = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        clear_mon();
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            s_axis_tvalid = 1'b0;
            s_axis_tlast = 1'b0;
            instr_fifo_full = 1'b0;
            pulse_fifo_full = 1'b0;
        end
        #1;
    endtask

    // Offers one beat until accepted; acc_cyc is the index of the accepting edge.
    task automatic drive_beat(input logic [31:0] d, input logic l, output int acc_cyc);
        int waits = 0;
        int gaps = 0;
        bit done = 0;
        acc_cyc = -1;
        while (!done) begin
            @(negedge clk);
            if (gap_en && gaps < 3 && $urandom_range(0, 3) == 0) begin
                s_axis_tvalid = 1'b0;
                gaps++;
            end else begin
                s_axis_tvalid = 1'b1;
                s_axis_tdata = d;
                s_axis_tlast = l;
            end
            instr_fifo_full = bp_en && ($urandom_range(0, 3) == 0);
            pulse_fifo_full = bp_en && ($urandom_range(0, 3) == 0);
            #1;
            if (s_axis_tvalid && s_axis_tready) begin
                done = 1;
                acc_cyc = cyc + 1;
            end
            @(posedge clk);
            waits++;
            if (!done && waits >= 200) begin
                n_vec++; n_err++;
                $display("FAIL beat_accept: data %08h not accepted after %0d cycles", d, waits);
                done = 1;
            end
        end
    endtask

    // Reference: apply the routing rules beat by beat over the whole stream.
    task automatic model_run(output int err, output int st);
        int mode = 0;
        int rem = 0;
        err = 0;
        exp_instr.delete();
        exp_pulse.delete();
        for (int i = 0; i < beat_d.size(); i++) begin
            logic [31:0] d;
            logic l;
            d = beat_d[i];
            l = beat_l[i];
            if (mode == 0) begin
                if (d[31:24] == 8'h00) begin
                    if (!l) begin err++; mode = 2; end
                end else if (d[31:24] == 8'h01) begin
                    if (d[15:0] == 16'd0) begin
                        if (!l) begin err++; mode = 2; end
                    end else if (l) begin
                        err++;
                    end else begin
                        mode = 1;
                        rem = int'(d[15:0]);
                    end
                end else begin
                    exp_instr.push_back(d);
                    if (!l) begin err++; mode = 2; end
                end
            end else if (mode == 1) begin
                exp_pulse.push_back(d);
                if (rem == 1) begin
                    if (l) mode = 0;
                    else begin err++; mode = 2; end
                end else if (l) begin
                    err++; mode = 0;
                end else begin
                    rem--;
                end
            end else begin
                if (l) mode = 0;
            end
        end
        // The stream ends with a long idle, so a pending payload times out.
        if (mode == 1) begin err++; mode = 0; end
        st = mode;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 32'h0600_0001;
        s_axis_tlast = 1'b1;
        instr_fifo_full = 1'b0;
        pulse_fifo_full = 1'b0;
        #1;
        n_vec++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL rst_tready: got %b want 0", s_axis_tready); end
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (instr_fifo_wr_en !== 1'b0 || pulse_fifo_wr_en !== 1'b0) begin n_err++; $display("FAIL rst_wr_en: got %b/%b want 0/0", instr_fifo_wr_en, pulse_fifo_wr_en); end
        n_vec++; if (instr_fifo_wr_data !== 32'd0 || pulse_fifo_wr_data !== 32'd0) begin n_err++; $display("FAIL rst_wr_data: got %08h/%08h want 0/0", instr_fifo_wr_data, pulse_fifo_wr_data); end
        n_vec++; if (err_count !== 16'd0) begin n_err++; $display("FAIL rst_err: got %0d want 0", err_count); end
        n_vec++; if (state_out !== 8'd0) begin n_err++; $display("FAIL rst_state: got %0d want 0", state_out); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        #1;
        n_vec++; if (s_axis_tready !== 1'b1) begin n_err++; $display("FAIL idle_tready: got %b want 1", s_axis_tready); end
        instr_fifo_full = 1'b1;
        #1;
        n_vec++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL idle_tready_full: got %b want 0", s_axis_tready); end
        instr_fifo_full = 1'b0;
        clear_mon();
    endtask

    task automatic test_load_basic();
        int a[5];
        do_reset();
        drive_beat(32'h0100_0004, 1'b0, a[0]);
        #1;
        n_vec++; if (state_out !== 8'd1 || busy !== 1'b1) begin n_err++; $display("FAIL load_enter: state %0d busy %b want 1/1", state_out, busy); end
        for (int k = 1; k <= 4; k++) drive_beat(32'(k), (k == 4), a[k]);
        idle_cycles(3);
        n_vec++; if (mon_pulse_q.size() != 4) begin n_err++; $display("FAIL load_count: got %0d want 4", mon_pulse_q.size()); end
        for (int k = 0; k < 4 && k < mon_pulse_q.size(); k++) begin
            n_vec++;
            if (mon_pulse_q[k] !== 32'(k + 1) || mon_pulse_c[k] != a[k + 1] || a[k + 1] != a[0] + k + 1) begin
                n_err++;
                $display("FAIL load_word%0d: data %08h at edge %0d want %08h at edge %0d", k, mon_pulse_q[k], mon_pulse_c[k], k + 1, a[0] + k + 1);
            end
        end
        n_vec++; if (mon_instr_q.size() != 0) begin n_err++; $display("FAIL load_instr: got %0d writes want 0", mon_instr_q.size()); end
        n_vec++; if (err_count !== 16'd0 || state_out !== 8'd0 || busy !== 1'b0) begin n_err++; $display("FAIL load_end: err %0d state %0d busy %b want 0/0/0", err_count, state_out, busy); end
    endtask

    task automatic test_instr_single();
        int a;
        do_reset();
        drive_beat(32'h060A_000A, 1'b1, a);
        #1;
        n_vec++; if (state_out !== 8'd0) begin n_err++; $display("FAIL instr_state: got %0d want 0", state_out); end
        idle_cycles(3);
        n_vec++;
        if (mon_instr_q.size() != 1 || mon_instr_q[0] !== 32'h060A_000A || mon_instr_c[0] != a) begin
            n_err++;
            $display("FAIL instr_write: %0d writes, first %08h, want one 060a000a at edge %0d", mon_instr_q.size(), (mon_instr_q.size() > 0) ? mon_instr_q[0] : 32'h0, a);
        end
        n_vec++; if (mon_pulse_q.size() != 0 || err_count !== 16'd0) begin n_err++; $display("FAIL instr_side: pulse writes %0d err %0d want 0/0", mon_pulse_q.size(), err_count); end
    endtask

    task automatic test_early_tlast();
        int a;
        do_reset();
        drive_beat(32'h0100_0003, 1'b0, a);
        drive_beat(32'h0000_0011, 1'b0, a);
        drive_beat(32'h0000_0022, 1'b1, a);
        #1;
        n_vec++; if (state_out !== 8'd0) begin n_err++; $display("FAIL early_state: got %0d want 0", state_out); end
        drive_beat(32'h0601_0203, 1'b1, a);
        idle_cycles(3);
        n_vec++;
        if (mon_pulse_q.size() != 2 || mon_pulse_q[0] !== 32'h11 || mon_pulse_q[1] !== 32'h22) begin
            n_err++; $display("FAIL early_pulse: got %0d writes want 2 (11,22)", mon_pulse_q.size());
        end
        n_vec++; if (err_count !== 16'd1) begin n_err++; $display("FAIL early_err: got %0d want 1", err_count); end
        n_vec++;
        if (mon_instr_q.size() != 1 || mon_instr_q[0] !== 32'h0601_0203) begin
            n_err++; $display("FAIL early_next: got %0d instr writes want one 06010203", mon_instr_q.size());
        end
    endtask

    task automatic test_drain();
        int a;
        do_reset();
        drive_beat(32'h0100_0002, 1'b0, a);
        drive_beat(32'h0000_00A0, 1'b0, a);
        drive_beat(32'h0000_00A1, 1'b0, a);
        #1;
        n_vec++; if (state_out !== 8'd2) begin n_err++; $display("FAIL drain_enter: got %0d want 2", state_out); end
        drive_beat(32'h0600_0000, 1'b0, a);
        drive_beat(32'h0100_0009, 1'b0, a);
        #1;
        n_vec++; if (state_out !== 8'd2) begin n_err++; $display("FAIL drain_hold: got %0d want 2", state_out); end
        drive_beat(32'h0700_0000, 1'b1, a);
        #1;
        n_vec++; if (state_out !== 8'd0) begin n_err++; $display("FAIL drain_exit: got %0d want 0", state_out); end
        idle_cycles(3);
        n_vec++; if (mon_pulse_q.size() != 2 || mon_instr_q.size() != 0) begin n_err++; $display("FAIL drain_writes: pulse %0d instr %0d want 2/0", mon_pulse_q.size(), mon_instr_q.size()); end
        n_vec++; if (err_count !== 16'd1) begin n_err++; $display("FAIL drain_err: got %0d want 1", err_count); end
    endtask

    task automatic test_timeout_stall();
        int a;
        int bad = 0;
        do_reset();
        drive_beat(32'h0100_0004, 1'b0, a);
        drive_beat(32'h0000_0005, 1'b0, a);
        repeat (50) begin
            @(negedge clk);
            s_axis_tvalid = 1'b1;
            s_axis_tdata = 32'hDEAD_BEEF;
            s_axis_tlast = 1'b0;
            pulse_fifo_full = 1'b1;
            #1;
            if (s_axis_tready !== 1'b0) bad++;
        end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL stall_tready: ready high in %0d of 50 stalled cycles, want 0", bad); end
        repeat (15) begin
            @(negedge clk);
            s_axis_tvalid = 1'b0;
            pulse_fifo_full = 1'b0;
            @(posedge clk);
        end
        #1;
        n_vec++; if (state_out !== 8'd1 || err_count !== 16'd0) begin n_err++; $display("FAIL timeout_early: state %0d err %0d after 15 idle, want 1/0", state_out, err_count); end
        @(posedge clk);
        #1;
        n_vec++; if (state_out !== 8'd0 || err_count !== 16'd1) begin n_err++; $display("FAIL timeout_fire: state %0d err %0d after 16 idle, want 0/1", state_out, err_count); end
        n_vec++; if (mon_pulse_q.size() != 1) begin n_err++; $display("FAIL timeout_writes: got %0d pulse writes want 1", mon_pulse_q.size()); end
    endtask

    task automatic test_saturation_and_rst();
        int a;
        do_reset();
        force dut.err_cnt_p1 = 16'hFFFF;
        @(posedge clk);
        #1;
        release dut.err_cnt_p1;
        drive_beat(32'h0100_0003, 1'b0, a);
        drive_beat(32'h0000_0001, 1'b1, a);
        drive_beat(32'h0100_0005, 1'b1, a);
        idle_cycles(2);
        n_vec++; if (err_count !== 16'hFFFF) begin n_err++; $display("FAIL err_saturate: got %04h want ffff", err_count); end
        drive_beat(32'h0100_0005, 1'b0, a);
        drive_beat(32'h0000_0007, 1'b0, a);
        drive_beat(32'h0000_0008, 1'b0, a);
        @(negedge clk);
        rst = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 32'h0000_0009;
        #1;
        n_vec++; if (s_axis_tready !== 1'b0) begin n_err++; $display("FAIL midrst_tready: got %b want 0", s_axis_tready); end
        @(posedge clk);
        #1;
        n_vec++;
        if (instr_fifo_wr_en !== 1'b0 || pulse_fifo_wr_en !== 1'b0 || pulse_fifo_wr_data !== 32'd0 || err_count !== 16'd0 || state_out !== 8'd0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midrst_outputs: wr_en %b/%b pdata %08h err %0d state %0d busy %b want all 0", instr_fifo_wr_en, pulse_fifo_wr_en, pulse_fifo_wr_data, err_count, state_out, busy);
        end
        @(negedge clk);
        rst = 1'b0;
        s_axis_tvalid = 1'b0;
        clear_mon();
        drive_beat(32'h0602_0000, 1'b1, a);
        idle_cycles(3);
        n_vec++; if (mon_instr_q.size() != 1 || err_count !== 16'd0) begin n_err++; $display("FAIL midrst_resume: instr writes %0d err %0d want 1/0", mon_instr_q.size(), err_count); end
    endtask

    task automatic test_back_to_back();
        int a[5];
        do_reset();
        drive_beat(32'h0100_0002, 1'b0, a[0]);
        drive_beat(32'h0000_00A1, 1'b0, a[1]);
        drive_beat(32'h0000_00A2, 1'b1, a[2]);
        drive_beat(32'h0700_0001, 1'b1, a[3]);
        drive_beat(32'h0000_0000, 1'b1, a[4]);
        idle_cycles(3);
        n_vec++; if (a[4] != a[0] + 4) begin n_err++; $display("FAIL b2b_rate: 5 beats over edges %0d..%0d want consecutive", a[0], a[4]); end
        n_vec++;
        if (mon_pulse_q.size() != 2 || mon_instr_q.size() != 1) begin
            n_err++; $display("FAIL b2b_counts: pulse %0d instr %0d want 2/1", mon_pulse_q.size(), mon_instr_q.size());
        end else begin
            n_vec++;
            if (mon_pulse_c[0] != a[1] || mon_pulse_c[1] != a[2] || mon_instr_c[0] != a[3] || mon_instr_q[0] !== 32'h0700_0001 || mon_pulse_q[1] !== 32'hA2) begin
                n_err++; $display("FAIL b2b_order: pulse edges %0d,%0d instr edge %0d want %0d,%0d,%0d", mon_pulse_c[0], mon_pulse_c[1], mon_instr_c[0], a[1], a[2], a[3]);
            end
        end
        n_vec++; if (err_count !== 16'd0) begin n_err++; $display("FAIL b2b_err: got %0d want 0", err_count); end
    endtask

    task automatic test_random(input int rounds);
        for (int r = 0; r < rounds; r++) begin
            int a;
            int exp_err;
            int exp_st;
            do_reset();
            beat_d.delete();
            beat_l.delete();
            for (int p = 0; p < 30; p++) begin
                int sel;
                int n;
                logic [7:0] op;
                logic [15:0] cnt;
                sel = int'($urandom_range(0, 5));
                if (sel == 0) op = 8'h00;
                else if (sel <= 2) op = 8'h01;
                else if (sel == 3) op = 8'h06;
                else op = 8'($urandom_range(2, 255));
                cnt = (op == 8'h01) ? 16'($urandom_range(0, 5)) : 16'($urandom);
                if (op == 8'h01) begin
                    n = int'(cnt) + int'($urandom_range(0, 2)) - 1;
                    if (n < 0) n = 0;
                end else begin
                    n = ($urandom_range(0, 3) == 0) ? 1 : 0;
                end
                beat_d.push_back({op, 8'($urandom), cnt});
                beat_l.push_back(1'b0);
                for (int k = 0; k < n; k++) begin
                    beat_d.push_back($urandom);
                    beat_l.push_back(1'b0);
                end
                beat_l[beat_l.size() - 1] = ($urandom_range(0, 7) != 0);
            end
            gap_en = 1;
            bp_en = 1;
            for (int i = 0; i < beat_d.size(); i++) drive_beat(beat_d[i], beat_l[i], a);
            gap_en = 0;
            bp_en = 0;
            idle_cycles(20);
            model_run(exp_err, exp_st);
            n_vec++; if (mon_instr_q.size() != exp_instr.size()) begin n_err++; $display("FAIL rand%0d_instr_n: got %0d want %0d", r, mon_instr_q.size(), exp_instr.size()); end
            for (int i = 0; i < exp_instr.size() && i < mon_instr_q.size(); i++) begin
                n_vec++; if (mon_instr_q[i] !== exp_instr[i]) begin n_err++; $display("FAIL rand%0d_instr[%0d]: got %08h want %08h", r, i, mon_instr_q[i], exp_instr[i]); end
            end
            n_vec++; if (mon_pulse_q.size() != exp_pulse.size()) begin n_err++; $display("FAIL rand%0d_pulse_n: got %0d want %0d", r, mon_pulse_q.size(), exp_pulse.size()); end
            for (int i = 0; i < exp_pulse.size() && i < mon_pulse_q.size(); i++) begin
                n_vec++; if (mon_pulse_q[i] !== exp_pulse[i]) begin n_err++; $display("FAIL rand%0d_pulse[%0d]: got %08h want %08h", r, i, mon_pulse_q[i], exp_pulse[i]); end
            end
            n_vec++; if (err_count !== 16'(exp_err)) begin n_err++; $display("FAIL rand%0d_err: got %0d want %0d", r, err_count, exp_err); end
            n_vec++; if (state_out !== 8'(exp_st)) begin n_err++; $display("FAIL rand%0d_state: got %0d want %0d", r, state_out, exp_st); end
        end
    endtask

    initial begin
        rst = 1'b1;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        instr_fifo_full = 1'b0;
        pulse_fifo_full = 1'b0;
        test_reset();
        test_load_basic();
        test_instr_single();
        test_early_tlast();
        test_drain();
        test_timeout_stall();
        test_saturation_and_rst();
        test_back_to_back();
        test_random(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/host_cmd_router.md
# host_cmd_router

Routes the 32-bit host command stream into the two FIFOs that feed `pulse_gen`: the instruction FIFO and the pulse FIFO. Each host packet starts with a header word. The header either loads a run of pulse words into the pulse FIFO or forwards itself as a single instruction word. The block enforces packet framing through `tlast`, length and stall timeout, and it counts framing errors. It sits between the host DMA/AXI-stream and the FIFO write ports upstream of `pulse_gen`.

## Interface
- `TIMEOUT_CYCLES`, default 1024: consecutive idle cycles (`tvalid` low) allowed mid-payload before the packet is aborted.
- `clk`  in  1  single clock for all logic.
- `rst`  in  1  synchronous, active-high reset.
- `s_axis_tdata`  in  32  host word.
- `s_axis_tvalid`  in  1  host word valid.
- `s_axis_tlast`  in  1  last word of packet.
- `s_axis_tready`  out  1  block accepts the word.
- `instr_fifo_full`  in  1  almost-full of the instruction FIFO; must assert with ≥2 free entries.
- `instr_fifo_wr_en`  out  1  write strobe.
- `instr_fifo_wr_data`  out  32  instruction word.
- `pulse_fifo_full`  in  1  almost-full of the pulse FIFO; must assert with ≥2 free entries.
- `pulse_fifo_wr_en`  out  1  write strobe.
- `pulse_fifo_wr_data`  out  32  pulse word.
- `err_count`  out  16  framing-error count; saturates at 16'hFFFF.
- `state_out`  out  8  current state: IDLE=0, PAYLOAD=1, DRAIN=2.
- `busy`  out  1  state≠IDLE or a write is pending.

## Operation
- A beat is accepted when `s_axis_tvalid & s_axis_tready`.
- Header format:
  - [31:24] opcode.
  - [23:16] arg.
  - [15:0] count.
- IDLE:
  - `tready` = !`instr_fifo_full`.
  - The accepted beat is decoded as a header.
- Opcode 8'h00 (NOP): the header is dropped.
  - With `tlast`=1: stay in IDLE.
  - With `tlast`=0: err++ and go to DRAIN.
- Opcode 8'h01 (LOAD_PULSES): the header is not forwarded. The payload counter loads with count.
  - count=0 and `tlast`=1: stay in IDLE.
  - count=0 and `tlast`=0: err++ and go to DRAIN.
  - count>0 and `tlast`=1: err++ and stay in IDLE (truncated packet).
  - count>0 and `tlast`=0: go to PAYLOAD.
- Any other opcode (e.g. 8'h06 sync-and-stream): the header word is written unchanged to the instruction FIFO.
  - With `tlast`=1: stay in IDLE.
  - With `tlast`=0: err++ and go to DRAIN. The header is still forwarded.
- PAYLOAD:
  - `tready` = !`pulse_fifo_full`.
  - Each accepted word is written to the pulse FIFO and the counter decrements.
  - On the final word (counter=1):
    - `tlast`=1: go to IDLE.
    - `tlast`=0: err++ and go to DRAIN.
  - Early `tlast` (counter>1): the word is still written, err++, go to IDLE.
- DRAIN:
  - `tready`=1.
  - Words are discarded until an accepted beat with `tlast`=1, then go to IDLE. No error is added at the drain end.
- Timeout, applies in PAYLOAD only:
  - The idle counter increments each cycle with `tvalid`=0.
  - It clears on any accepted beat and on entry to PAYLOAD.
  - Cycles stalled by `pulse_fifo_full` with `tvalid`=1 are not counted.
  - When the count reaches `TIMEOUT_CYCLES`: err++, go to IDLE, discard the remaining count.
- The stream is processed in order, so an instruction header following a pulse load is written only after every payload word of that load.
- The error increment saturates. Increments are at most one per cycle.

## Timing
- Reset values:
  - `s_axis_tready`=0 during `rst`.
  - Both `wr_en`=0; both `wr_data`=0.
  - `err_count`=0, `state_out`=0, `busy`=0.
  - All counters are 0.
- `tready` is combinational from state and the full inputs. It never depends on `tvalid`.
- Write latency: `wr_en`/`wr_data` are registered. They assert exactly 1 cycle after the accepting edge and last 1 cycle per word. This lag is why the full inputs need ≥2 entries of headroom.
- Throughput: 1 word/cycle in PAYLOAD, IDLE and DRAIN when not back-pressured.
- State changes take effect on the accepting edge. The next cycle's `tready` uses the new state.
- `err_count` updates 1 cycle after the offending accepted beat or the timeout cycle.
- `rst` asserted mid-packet:
  - Return to IDLE next edge and clear counters and `err_count`.
  - A write registered in the same cycle is suppressed.
  - The remainder of the host packet is then parsed as a new header; the host must reset too.

## Test plan
- Header {8'h01,8'h00,16'd4} + 4 words 1..4, `tlast` on word 4 → pulse FIFO gets 1,2,3,4 on consecutive cycles, each 1 cycle after acceptance; instr FIFO untouched; `err_count`=0; end state IDLE.
- Single word {8'h06,8'h0A,16'h000A} with `tlast` → one instr write of 32'h060A000A; `state_out` stays 0.
- LOAD count=3 with `tlast` on payload word 2 → 2 pulse writes, `err_count`=1, IDLE. The next packet {8'h06,...} is forwarded normally.
- LOAD count=2 with no `tlast` on word 2, then 3 junk words ending in `tlast` → 2 pulse writes, `state_out`=2 until the tlast beat, `err_count`=1, no writes from the junk.
- `pulse_fifo_full` held high for 50 cycles mid-payload with `tvalid`=1 (`TIMEOUT_CYCLES`=16) → `tready`=0 and no timeout. Then `tvalid`=0 for 16 cycles → `err_count`=1 and IDLE.
- Saturation: preload by forcing `err_count` to 16'hFFFF, then one early-`tlast` packet → `err_count` remains 16'hFFFF. Asserting `rst` mid-PAYLOAD → all outputs at reset values next cycle.
